// File: rtl/sprite_mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency sprite ROM between requesters,
// with a tag pipeline for returns and per-frame grant counters.
module sprite_mem_arbiter #(
  parameter int N_REQ  = 4,
  parameter int AW     = 18,
  parameter int DW     = 8,
  parameter int RD_LAT = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  frame_start_i,
  input  logic [N_REQ-1:0]      req_i,
  input  logic [N_REQ*AW-1:0]   addr_i,
  input  logic [N_REQ-1:0]      req_mask_i,
  output logic [N_REQ-1:0]      gnt_o,
  output logic [AW-1:0]         mem_addr_o,
  output logic                  mem_rd_o,
  input  logic [DW-1:0]         mem_rdata_i,
  output logic [DW-1:0]         rdata_o,
  output logic [N_REQ-1:0]      rvalid_o,
  output logic [N_REQ*16-1:0]   grant_cnt_o
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] gnt;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    win;
  logic             any;
  logic             hit;
  logic [AW-1:0]    sel_addr;
  logic [AW-1:0]    mem_addr_q, mem_addr_d;

  logic [RD_LAT-1:0] tv_q;
  logic [IW-1:0]     ti_q [RD_LAT];

  logic [15:0] live_q [N_REQ];
  logic [15:0] cnt_q  [N_REQ];

  assign elig = req_i & req_mask_i;

  // First eligible index at or after ptr, wrapping past N_REQ-1.
  always_comb begin : arb
    logic [IW-1:0] idx;
    int j;
    win = '0;
    any = 1'b0;
    idx = '0;
    j   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(ptr_q) + k;
      if (j >= N_REQ) j = j - N_REQ;
      idx = IW'(j);
      if (!any && elig[idx]) begin
        any = 1'b1;
        win = idx;
      end
    end
  end

  assign hit = any & rst_ni;

  always_comb begin
    gnt = '0;
    for (int i = 0; i < N_REQ; i++) begin
      gnt[i] = hit && (win == IW'(i));
    end
  end

  always_comb begin
    sel_addr = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) sel_addr = addr_i[i*AW +: AW];
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (hit) begin
      ptr_d = (win == IW'(N_REQ - 1)) ? '0 : win + 1'b1;
    end
  end

  assign mem_addr_d = hit ? sel_addr : mem_addr_q;
  assign mem_addr_o = mem_addr_d;
  assign mem_rd_o   = hit;
  assign gnt_o      = gnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q      <= '0;
      mem_addr_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tv_q <= '0;
      for (int s = 0; s < RD_LAT; s++) ti_q[s] <= '0;
    end else begin
      tv_q[0] <= hit;
      ti_q[0] <= win;
      for (int s = 1; s < RD_LAT; s++) begin
        tv_q[s] <= tv_q[s-1];
        ti_q[s] <= ti_q[s-1];
      end
    end
  end

  always_comb begin
    rvalid_o = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rvalid_o[i] = tv_q[RD_LAT-1] && (ti_q[RD_LAT-1] == IW'(i));
    end
  end

  // ROM data is valid exactly in the return cycle, so pass it through.
  assign rdata_o = (|rvalid_o) ? mem_rdata_i : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N_REQ; i++) begin
        live_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (frame_start_i) begin
          cnt_q[i]  <= live_q[i];
          live_q[i] <= {15'd0, gnt[i]};
        end else if (gnt[i] && live_q[i] != 16'hFFFF) begin
          live_q[i] <= live_q[i] + 16'd1;
        end
      end
    end
  end

  always_comb begin
    grant_cnt_o = '0;
    for (int i = 0; i < N_REQ; i++) begin
      grant_cnt_o[i*16 +: 16] = cnt_q[i];
    end
  end

endmodule
